// File: rtl/lfsr_64bit_checker.sv
// lfsr_64bit_checker: locks onto a 64-bit LFSR word stream, flywheels through errors and counts mismatches
module lfsr_64bit_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
) (
    input  logic        clk,
    input  logic        s_rst_n,
    input  logic        in_valid,
    input  logic [63:0] in_data,
    input  logic        clr_stats,
    output logic        locked,
    output logic        mismatch,
    output logic [31:0] err_count,
    output logic [31:0] word_count,
    output logic [63:0] expected_out
);
    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
    localparam logic [3:0] LOCK_LIM = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_LIM = 4'(LOSS_CNT);
    state_t      state, state_n;
    logic [63:0] ref_word, ref_n;
    logic [3:0]  match_cnt, match_n, miss_cnt, miss_n;
    logic        hit, miss_pulse, count_word, count_err;
    function automatic logic [63:0] nxt(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction
    assign hit = in_data == nxt(ref_word);
    assign expected_out = nxt(ref_word);
    // next-state decode: only valid words move the tracker, idle cycles hold everything
    always_comb begin
        state_n    = state;
        ref_n      = ref_word;
        match_n    = match_cnt;
        miss_n     = miss_cnt;
        miss_pulse = 1'b0;
        count_word = 1'b0;
        count_err  = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (in_data != '0) begin
                        ref_n   = in_data;
                        match_n = '0;
                        state_n = VERIFY;
                    end
                end
                VERIFY: begin
                    if (hit) begin
                        ref_n   = in_data;
                        match_n = match_cnt + 4'd1;
                        if (match_n == LOCK_LIM) begin
                            state_n = LOCKED;
                            miss_n  = '0;
                        end
                    end else if (in_data != '0) begin
                        ref_n   = in_data;
                        match_n = '0;
                    end else begin
                        state_n = HUNT;
                    end
                end
                LOCKED: begin
                    count_word = 1'b1;
                    if (hit) begin
                        ref_n  = in_data;
                        miss_n = '0;
                    end else begin
                        ref_n      = nxt(ref_word);
                        miss_n     = miss_cnt + 4'd1;
                        count_err  = 1'b1;
                        miss_pulse = 1'b1;
                        if (miss_n == LOSS_LIM) begin
                            state_n = HUNT;
                            miss_n  = '0;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end
    // state, reference and registered outputs; clr_stats overrides a same-cycle increment
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state      <= HUNT;
            ref_word   <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            locked     <= 1'b0;
            mismatch   <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
        end else begin
            state      <= state_n;
            ref_word   <= ref_n;
            match_cnt  <= match_n;
            miss_cnt   <= miss_n;
            locked     <= state_n == LOCKED;
            mismatch   <= miss_pulse;
            err_count  <= clr_stats ? '0 : (count_err && ~&err_count) ? err_count + 32'd1 : err_count;
            word_count <= clr_stats ? '0 : (count_word && ~&word_count) ? word_count + 32'd1 : word_count;
        end
    end
endmodule

// File: tb/tb_lfsr_64bit_checker.sv
// tb_lfsr_64bit_checker: scoreboard-driven bench for the LFSR checker
module tb_lfsr_64bit_checker;
    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;
    localparam logic [63:0] SEED = 64'hFEDCBA9876543210;
    typedef struct {
        logic        l;
        logic        m;
        logic [31:0] e;
        logic [31:0] w;
        logic [63:0] x;
    } exp_t;
    logic        clk = 1'b0;
    logic        s_rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        clr_stats = 1'b0;
    logic        locked, mismatch;
    logic [31:0] err_count, word_count;
    logic [63:0] expected_out;
    int          checks = 0;
    int          errors = 0;
    exp_t        sbq[$];
    exp_t        mon_e;
    int          m_state;
    logic [63:0] m_ref;
    int          m_match, m_miss;
    logic [31:0] m_err, m_words;
    logic        m_mis;
    logic [63:0] w;

    lfsr_64bit_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
        .clk(clk), .s_rst_n(s_rst_n), .in_valid(in_valid), .in_data(in_data),
        .clr_stats(clr_stats), .locked(locked), .mismatch(mismatch),
        .err_count(err_count), .word_count(word_count), .expected_out(expected_out)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] tb_nxt(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    task automatic model_step(input logic v, input logic [63:0] d, input logic c);
        m_mis = 1'b0;
        if (v) begin
            if (m_state == 0) begin
                if (d != 0) begin m_ref = d; m_match = 0; m_state = 1; end
            end else if (m_state == 1) begin
                if (d == tb_nxt(m_ref)) begin
                    m_ref = d; m_match++;
                    if (m_match == LOCK_CNT) begin m_state = 2; m_miss = 0; end
                end else if (d != 0) begin
                    m_ref = d; m_match = 0;
                end else begin
                    m_state = 0;
                end
            end else begin
                if (m_words != 32'hFFFFFFFF) m_words++;
                if (d == tb_nxt(m_ref)) begin
                    m_ref = d; m_miss = 0;
                end else begin
                    m_ref = tb_nxt(m_ref); m_miss++; m_mis = 1'b1;
                    if (m_err != 32'hFFFFFFFF) m_err++;
                    if (m_miss == LOSS_CNT) begin m_state = 0; m_miss = 0; end
                end
            end
        end
        if (c) begin m_err = 0; m_words = 0; end
    endtask

    task automatic step(input logic v, input logic [63:0] d, input logic c);
        exp_t e;
        @(negedge clk);
        in_valid = v; in_data = d; clr_stats = c;
        model_step(v, d, c);
        e.l = m_state == 2; e.m = m_mis; e.e = m_err; e.w = m_words; e.x = tb_nxt(m_ref);
        sbq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // scoreboard consumer: compare every registered output one step after the edge
    always @(posedge clk) begin
        #1;
        if (s_rst_n && sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            checks += 5;
            if (locked !== mon_e.l) begin errors++; $display("FAIL sb_locked: got %b expected %b", locked, mon_e.l); end
            if (mismatch !== mon_e.m) begin errors++; $display("FAIL sb_mismatch: got %b expected %b", mismatch, mon_e.m); end
            if (err_count !== mon_e.e) begin errors++; $display("FAIL sb_err_count: got %0d expected %0d", err_count, mon_e.e); end
            if (word_count !== mon_e.w) begin errors++; $display("FAIL sb_word_count: got %0d expected %0d", word_count, mon_e.w); end
            if (expected_out !== mon_e.x) begin errors++; $display("FAIL sb_expected_out: got %h expected %h", expected_out, mon_e.x); end
        end
    end

    task automatic test_reset();
        #1;
        s_rst_n = 1'b0; in_valid = 1'b0; clr_stats = 1'b0;
        #1;
        checks++;
        if (locked !== 1'b0 || mismatch !== 1'b0 || err_count !== 32'd0 || word_count !== 32'd0 || expected_out !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: got locked=%b mismatch=%b err=%0d words=%0d exp=%h expected all zero",
                     locked, mismatch, err_count, word_count, expected_out);
        end
        m_state = 0; m_ref = 0; m_match = 0; m_miss = 0; m_err = 0; m_words = 0; m_mis = 0;
        sbq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        s_rst_n = 1'b1;
    endtask

    task automatic test_lock();
        test_reset();
        w = SEED;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, w, 1'b0);
            w = tb_nxt(w);
            if (i == 3) begin
                checks++;
                if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b expected 0", locked); end
            end
        end
        checks += 3;
        if (locked !== 1'b1) begin errors++; $display("FAIL lock_5th: got %b expected 1", locked); end
        if (err_count !== 32'd0) begin errors++; $display("FAIL lock_err: got %0d expected 0", err_count); end
        if (word_count !== 32'd0) begin errors++; $display("FAIL lock_words: got %0d expected 0", word_count); end
    endtask

    task automatic test_flywheel();
        step(1'b1, w, 1'b0);
        w = tb_nxt(w);
        step(1'b1, w ^ 64'd1, 1'b0);
        w = tb_nxt(w);
        checks += 3;
        if (mismatch !== 1'b1) begin errors++; $display("FAIL fly_pulse: got %b expected 1", mismatch); end
        if (err_count !== 32'd1) begin errors++; $display("FAIL fly_err: got %0d expected 1", err_count); end
        if (locked !== 1'b1) begin errors++; $display("FAIL fly_locked: got %b expected 1", locked); end
        step(1'b1, w, 1'b0);
        w = tb_nxt(w);
        checks += 3;
        if (mismatch !== 1'b0) begin errors++; $display("FAIL fly_resume: got %b expected 0", mismatch); end
        if (word_count !== 32'd3) begin errors++; $display("FAIL fly_words: got %0d expected 3", word_count); end
        if (err_count !== 32'd1) begin errors++; $display("FAIL fly_err_hold: got %0d expected 1", err_count); end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < LOSS_CNT - 1; i++) begin
                step(1'b1, w ^ 64'd2, 1'b0);
                w = tb_nxt(w);
            end
            step(1'b1, w, 1'b0);
            w = tb_nxt(w);
        end
        checks += 2;
        if (locked !== 1'b1) begin errors++; $display("FAIL fly_below_loss: got %b expected 1", locked); end
        if (err_count !== 32'd5) begin errors++; $display("FAIL fly_err5: got %0d expected 5", err_count); end
    endtask

    task automatic test_loss();
        logic [63:0] r;
        logic [31:0] e0;
        e0 = err_count;
        for (int i = 0; i < LOSS_CNT; i++) begin
            r = {$urandom, $urandom} | 64'h1;
            if (r == tb_nxt(m_ref)) r = r ^ 64'h10;
            step(1'b1, r, 1'b0);
            if (i < LOSS_CNT - 1) begin
                checks++;
                if (locked !== 1'b1) begin errors++; $display("FAIL loss_early: got %b expected 1", locked); end
            end
        end
        checks += 2;
        if (locked !== 1'b0) begin errors++; $display("FAIL loss_drop: got %b expected 0", locked); end
        if (err_count !== e0 + 32'd3) begin errors++; $display("FAIL loss_err: got %0d expected %0d", err_count, e0 + 32'd3); end
        w = {$urandom, $urandom} | 64'h8000;
        step(1'b1, w, 1'b0);
        checks++;
        if (expected_out !== tb_nxt(w)) begin errors++; $display("FAIL loss_reload: got %h expected %h", expected_out, tb_nxt(w)); end
        for (int i = 0; i < LOCK_CNT; i++) begin
            w = tb_nxt(w);
            step(1'b1, w, 1'b0);
        end
        w = tb_nxt(w);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL loss_relock: got %b expected 1", locked); end
    endtask

    task automatic test_clr();
        step(1'b1, w ^ 64'h80, 1'b1);
        w = tb_nxt(w);
        checks += 4;
        if (err_count !== 32'd0) begin errors++; $display("FAIL clr_err: got %0d expected 0", err_count); end
        if (word_count !== 32'd0) begin errors++; $display("FAIL clr_words: got %0d expected 0", word_count); end
        if (mismatch !== 1'b1) begin errors++; $display("FAIL clr_pulse: got %b expected 1", mismatch); end
        if (locked !== 1'b1) begin errors++; $display("FAIL clr_locked: got %b expected 1", locked); end
        step(1'b1, w, 1'b0);
        w = tb_nxt(w);
        checks++;
        if (word_count !== 32'd1) begin errors++; $display("FAIL clr_restart: got %0d expected 1", word_count); end
    endtask

    task automatic test_zero();
        test_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 64'd0, 1'b0);
            checks++;
            if (locked !== 1'b0 || mismatch !== 1'b0) begin
                errors++; $display("FAIL zero_hunt: got locked=%b mismatch=%b expected 0/0", locked, mismatch);
            end
        end
        checks++;
        if (expected_out !== 64'd0) begin errors++; $display("FAIL zero_ref: got %h expected 0", expected_out); end
    endtask

    task automatic test_toggle();
        logic [63:0] prev;
        test_reset();
        w = SEED;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                step(1'b1, w, 1'b0);
                w = tb_nxt(w);
            end else begin
                prev = expected_out;
                step(1'b0, {$urandom, $urandom}, 1'b0);
                checks++;
                if (expected_out !== prev) begin errors++; $display("FAIL idle_hold: got %h expected %h", expected_out, prev); end
            end
            if (i == 6) begin
                checks++;
                if (locked !== 1'b0) begin errors++; $display("FAIL toggle_early: got %b expected 0", locked); end
            end
        end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL toggle_lock: got %b expected 1", locked); end
    endtask

    task automatic test_back_to_back();
        test_reset();
        for (int i = 0; i < LOCK_CNT + 1; i++) begin
            step(1'b1, w, 1'b0);
            w = tb_nxt(w);
            if (i == LOCK_CNT - 1) begin
                checks++;
                if (locked !== 1'b0) begin errors++; $display("FAIL rst_relock_early: got %b expected 0", locked); end
            end
        end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL rst_relock: got %b expected 1", locked); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        test_lock();
        test_flywheel();
        test_loss();
        test_clr();
        test_zero();
        test_toggle();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
